// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window controller.
//   - conv_state_e : controller FSM state encoding
//   - kk()         : number of window/coefficient elements for a kernel size
//   - result_count : windows produced per frame
//   - elem_lsb()   : LSB position of element idx on a flat multi-element bus
package conv_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_COEF = 3'd0,
    ST_FILL      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_MAC  = 3'd3,
    ST_OUTPUT    = 3'd4
  } conv_state_e;

  function automatic int kk(input int k);
    return k * k;
  endfunction

  function automatic int result_count(input int w, input int h, input int k);
    return (w - k + 1) * (h - k + 1);
  endfunction

  function automatic int elem_lsb(input int idx, input int width);
    return idx * width;
  endfunction

  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_IMG_WIDTH   = 32;
  localparam int DEF_IMG_HEIGHT  = 32;
  localparam int DEF_KK          = kk(DEF_KERNEL_SIZE);
  localparam int DEF_RESULTS     = result_count(DEF_IMG_WIDTH, DEF_IMG_HEIGHT, DEF_KERNEL_SIZE);

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay, built as a RAM-style circular buffer.
//   clk, rst_n : clock and asynchronous active-low reset
//   push       : accept din this cycle
//   din        : pixel written at the current pointer
//   dout       : pixel written IMG_WIDTH pushes ago (read before overwrite)
module conv_line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int PW = $clog2(IMG_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] mem_d [IMG_WIDTH];
  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         ptr_d;

  // The slot about to be overwritten holds the pixel from one row earlier.
  assign dout = mem_q[ptr_q];

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (push) begin
      mem_d[ptr_q] = din;
      ptr_d = (ptr_q == PW'(IMG_WIDTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < IMG_WIDTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/axi_conv_window_controller.sv
// K x K convolution window controller.
// Loads K*K signed coefficients, then a row-major frame of unsigned pixels
// from one AXI-Stream slave, forms every fully valid K x K window with K-1
// line buffers plus a window shift register, hands each window and the
// coefficients to an external multiply/add array and forwards each returned
// sum on an AXI-Stream master.
//   axi_clk, axi_reset_n      : clock, asynchronous active-low reset
//   s_axis_*                  : coefficient / pixel input stream
//   mul_a, mul_b, mul_start   : window, coefficients, one-cycle array request
//   mac_done, mac_sum         : array result pulse and sum
//   m_axis_*                  : result output stream (last = final window)
//   busy                      : low only when idle awaiting coefficients
//   err_last                  : sticky misplaced/missing s_axis_last
// Both streams: a beat transfers on a rising edge where valid and ready are
// both high; the source holds data/last stable while valid is high and ready
// is low, and valid never depends on ready.
module axi_conv_window_controller
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH+6
) (
  input  logic                                       axi_clk,
  input  logic                                       axi_reset_n,
  input  logic                                       s_axis_valid,
  output logic                                       s_axis_ready,
  input  logic [DATA_WIDTH-1:0]                      s_axis_data,
  input  logic                                       s_axis_last,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] mul_a,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] mul_b,
  output logic                                       mul_start,
  input  logic                                       mac_done,
  input  logic [ACC_WIDTH-1:0]                       mac_sum,
  output logic                                       m_axis_valid,
  input  logic                                       m_axis_ready,
  output logic [ACC_WIDTH-1:0]                       m_axis_data,
  output logic                                       m_axis_last,
  output logic                                       busy,
  output logic                                       err_last
);

  localparam int KK = kk(KERNEL_SIZE);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int NW = $clog2(KK);

  conv_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] coef_q [KK];
  logic [DATA_WIDTH-1:0] coef_d [KK];
  logic [DATA_WIDTH-1:0] win_q  [KK];
  logic [DATA_WIDTH-1:0] win_d  [KK];
  logic [NW-1:0]         coef_cnt_q, coef_cnt_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  final_q, final_d;
  logic [ACC_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  err_q, err_d;
  logic                  rdy_en_q, rdy_en_d;

  logic [DATA_WIDTH-1:0] lb_din  [KERNEL_SIZE-1];
  logic [DATA_WIDTH-1:0] lb_dout [KERNEL_SIZE-1];
  logic [DATA_WIDTH-1:0] new_col [KERNEL_SIZE];

  logic s_hs, coef_wr, pix_push, coef_done;
  logic col_end, row_end, frame_end, win_ready;

  assign s_hs      = s_axis_valid & s_axis_ready;
  assign coef_wr   = s_hs & (state_q == ST_LOAD_COEF);
  assign pix_push  = s_hs & (state_q == ST_FILL);
  assign coef_done = (coef_cnt_q == NW'(KK - 1));
  assign col_end   = (col_q == CW'(IMG_WIDTH - 1));
  assign row_end   = (row_q == RW'(IMG_HEIGHT - 1));
  assign frame_end = col_end & row_end;
  // The accepted pixel is the bottom-right corner of a complete window.
  assign win_ready = (row_q >= RW'(KERNEL_SIZE - 1)) && (col_q >= CW'(KERNEL_SIZE - 1));

  // Line buffers are chained: buffer j delays the stream by j+1 rows.
  for (genvar j = 0; j < KERNEL_SIZE - 1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign lb_din[j] = s_axis_data;
    end else begin : g_chain
      assign lb_din[j] = lb_dout[j-1];
    end
    conv_line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .IMG_WIDTH (IMG_WIDTH)
    ) u_lb (
      .clk  (axi_clk),
      .rst_n(axi_reset_n),
      .push (pix_push),
      .din  (lb_din[j]),
      .dout (lb_dout[j])
    );
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) state_q <= ST_LOAD_COEF;
    else              state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD_COEF: if (coef_wr && coef_done) state_d = ST_FILL;
      ST_FILL:      if (pix_push && win_ready) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_MAC;
      ST_WAIT_MAC:  if (mac_done) state_d = ST_OUTPUT;
      ST_OUTPUT:    if (m_axis_ready) state_d = final_q ? ST_LOAD_COEF : ST_FILL;
      default:      state_d = ST_LOAD_COEF;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    s_axis_ready = rdy_en_q & ((state_q == ST_LOAD_COEF) | (state_q == ST_FILL));
    mul_start    = (state_q == ST_ISSUE);
    m_axis_valid = (state_q == ST_OUTPUT);
    m_axis_last  = (state_q == ST_OUTPUT) & final_q;
    m_axis_data  = out_data_q;
    busy         = !((state_q == ST_LOAD_COEF) && (coef_cnt_q == '0));
    err_last     = err_q;
  end

  // Window and coefficients only change while loading/filling, so the
  // array sees them stable from the request until the sum returns.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < KK; i++) begin
      mul_a[elem_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = win_q[i];
      mul_b[elem_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = coef_q[i];
    end
  end

  // Column entering the window: bottom row is the new pixel, upper rows
  // come from progressively deeper line buffers.
  always_comb begin
    for (int r = 0; r < KERNEL_SIZE; r++) new_col[r] = '0;
    new_col[KERNEL_SIZE-1] = s_axis_data;
    for (int r = 0; r < KERNEL_SIZE - 1; r++) new_col[r] = lb_dout[KERNEL_SIZE-2-r];
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    coef_d     = coef_q;
    win_d      = win_q;
    coef_cnt_d = coef_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    final_d    = final_q;
    out_data_d = out_data_q;
    rdy_en_d   = 1'b1;
    err_d      = err_q
               | (coef_wr  & (s_axis_last != coef_done))
               | (pix_push & (s_axis_last != frame_end));

    if (coef_wr) begin
      coef_d[coef_cnt_q] = s_axis_data;
      coef_cnt_d = coef_done ? '0 : coef_cnt_q + 1'b1;
      if (coef_done) begin
        col_d = '0;
        row_d = '0;
      end
    end

    if (pix_push) begin
      // Shift every window row one column left (oldest column drops out).
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++)
          win_d[r*KERNEL_SIZE + c] = win_q[r*KERNEL_SIZE + c + 1];
        win_d[r*KERNEL_SIZE + KERNEL_SIZE - 1] = new_col[r];
      end
      final_d = frame_end;
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if ((state_q == ST_WAIT_MAC) && mac_done) out_data_d = mac_sum;
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      for (int i = 0; i < KK; i++) begin
        coef_q[i] <= '0;
        win_q[i]  <= '0;
      end
      coef_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      final_q    <= 1'b0;
      out_data_q <= '0;
      err_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      coef_q     <= coef_d;
      win_q      <= win_d;
      coef_cnt_q <= coef_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      final_q    <= final_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_axi_conv_window_controller.sv
module tb_axi_conv_window_controller;

  localparam int DW   = 16;
  localparam int K    = 3;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int ACC  = 2*DW+6;
  localparam int KK   = K*K;
  localparam int NPIX = W*H;
  localparam int BW   = KK*DW;

  // ---------------- clock / reset ----------------
  logic axi_clk = 1'b0;
  logic axi_reset_n = 1'b0;
  always #5 axi_clk = ~axi_clk;

  logic            s_axis_valid = 1'b0;
  logic            s_axis_ready;
  logic [DW-1:0]   s_axis_data = '0;
  logic            s_axis_last = 1'b0;
  logic [BW-1:0]   mul_a, mul_b;
  logic            mul_start;
  logic            mac_done = 1'b0;
  logic [ACC-1:0]  mac_sum = '0;
  logic            m_axis_valid;
  logic            m_axis_ready = 1'b0;
  logic [ACC-1:0]  m_axis_data;
  logic            m_axis_last;
  logic            busy;
  logic            err_last;

  axi_conv_window_controller #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ACC_WIDTH(ACC)
  ) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mac_done(mac_done), .mac_sum(mac_sum),
    .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
    .busy(busy), .err_last(err_last)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [ACC:0]    exp_q[$];      // {last, sum}
  logic [2*BW-1:0] exp_ab_q[$];   // {mul_b, mul_a}
  logic [DW-1:0]   coef_m [KK];
  logic [DW-1:0]   img_m  [NPIX];
  bit              exp_err = 1'b0;
  int              rdy_mode = 1;  // 0 hold low, 1 hold high, 2 random

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every valid window from image coordinates, dot product with
  // signed coefficients, truncated to ACC bits.
  task automatic push_expect();
    longint        sum;
    logic [BW-1:0] a, b;
    logic [ACC-1:0] res;
    logic          last;
    int            i;
    for (int r0 = 0; r0 <= H - K; r0++) begin
      for (int c0 = 0; c0 <= W - K; c0++) begin
        sum = 0;
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            i = r*K + c;
            a[i*DW +: DW] = img_m[(r0 + r)*W + c0 + c];
            b[i*DW +: DW] = coef_m[i];
            sum += longint'($signed(coef_m[i])) * longint'(img_m[(r0 + r)*W + c0 + c]);
          end
        end
        res  = sum[ACC-1:0];
        last = (r0 == H - K) && (c0 == W - K);
        exp_q.push_back({last, res});
        exp_ab_q.push_back({b, a});
      end
    end
  endtask

  // ---------------- m_axis_ready driver ----------------
  always @(posedge axi_clk) begin
    #1;
    m_axis_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  // ---------------- output monitor ----------------
  always @(negedge axi_clk) begin
    if (axi_reset_n && m_axis_valid && m_axis_ready) begin
      if (exp_q.size() == 0) chk("out_unexpected", 320'(exp_q.size()), 320'(1));
      else chk("out_result", 320'({m_axis_last, m_axis_data}), 320'(exp_q.pop_front()));
    end
  end

  // ---------------- external array model ----------------
  initial begin : array_model
    logic [2*BW-1:0] ab;
    longint          s;
    forever begin
      @(negedge axi_clk);
      if (mul_start) begin
        if (exp_ab_q.size() == 0) chk("mul_unexpected", 320'(exp_ab_q.size()), 320'(1));
        else begin
          ab = exp_ab_q.pop_front();
          chk("mul_a", 320'(mul_a), 320'(ab[BW-1:0]));
          chk("mul_b", 320'(mul_b), 320'(ab[2*BW-1:BW]));
        end
        s = 0;
        for (int i = 0; i < KK; i++)
          s += longint'($signed(mul_b[i*DW +: DW])) * longint'(mul_a[i*DW +: DW]);
        @(negedge axi_clk);
        chk("mul_start_pulse", 320'(mul_start), 320'(1'b0));
        repeat (3) @(posedge axi_clk);
        #1;
        mac_done = 1'b1;
        mac_sum  = s[ACC-1:0];
        @(posedge axi_clk);
        #1;
        mac_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n = 0;
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_last  = l;
    @(negedge axi_clk);
    while (!s_axis_ready && n < 200) begin
      @(negedge axi_clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 320'(n), 320'(0));
    @(posedge axi_clk);
    #1;
    s_axis_valid = 1'b0;
  endtask

  task automatic send_coefs(input int extra_last_at);
    logic req, l;
    for (int i = 0; i < KK; i++) begin
      req = (i == KK - 1);
      l   = req || (i == extra_last_at);
      send_beat(coef_m[i], l);
      if (l != req) exp_err = 1'b1;
      chk("err_last_coef", 320'(err_last), 320'(exp_err));
      if (i == 0) chk("busy_loading", 320'(busy), 320'(1'b1));
    end
  endtask

  task automatic send_pixels(input int from, input int to, input bit omit_last);
    logic req, l;
    for (int p = from; p <= to; p++) begin
      req = (p == NPIX - 1);
      l   = req && !omit_last;
      send_beat(img_m[p], l);
      if (l != req) exp_err = 1'b1;
    end
    chk("err_last_pix", 320'(err_last), 320'(exp_err));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge axi_clk);
      n++;
    end
    chk("drain", 320'(exp_q.size()), 320'(0));
    @(posedge axi_clk);
    #1;
  endtask

  task automatic do_reset();
    axi_reset_n = 1'b0;
    @(negedge axi_clk);
    chk("rst_s_ready",  320'(s_axis_ready), 320'(1'b0));
    chk("rst_mul_start",320'(mul_start),    320'(1'b0));
    chk("rst_mul_a",    320'(mul_a),        320'(0));
    chk("rst_mul_b",    320'(mul_b),        320'(0));
    chk("rst_m_valid",  320'(m_axis_valid), 320'(1'b0));
    chk("rst_m_data",   320'(m_axis_data),  320'(0));
    chk("rst_m_last",   320'(m_axis_last),  320'(1'b0));
    chk("rst_busy",     320'(busy),         320'(1'b0));
    chk("rst_err_last", 320'(err_last),     320'(1'b0));
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    #1;
    chk("rst_ready_held", 320'(s_axis_ready), 320'(1'b0));
    @(posedge axi_clk);
    #1;
    chk("rst_ready_up", 320'(s_axis_ready), 320'(1'b1));
    chk("rst_idle_busy", 320'(busy), 320'(1'b0));
  endtask

  task automatic set_coefs_const(input logic [DW-1:0] v);
    for (int i = 0; i < KK; i++) coef_m[i] = v;
  endtask

  task automatic set_img_seq();
    for (int p = 0; p < NPIX; p++) img_m[p] = DW'(p + 1);
  endtask

  task automatic set_random();
    int v;
    for (int i = 0; i < KK; i++) begin
      v = $urandom_range(0, 600) - 300;
      coef_m[i] = v[DW-1:0];
    end
    for (int p = 0; p < NPIX; p++) img_m[p] = DW'($urandom_range(0, 65535));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    do_reset();

    // Basic frame, plus request/ready timing around the first window.
    rdy_mode = 1;
    set_coefs_const(16'd1);
    set_img_seq();
    push_expect();
    send_coefs(-1);
    send_pixels(0, 10, 1'b0);
    chk("issue_mul_start", 320'(mul_start), 320'(1'b1));
    chk("issue_s_ready",   320'(s_axis_ready), 320'(1'b0));
    send_pixels(11, NPIX - 1, 1'b0);
    wait_drain();
    chk("frame_end_idle", 320'(busy), 320'(1'b0));

    // Signed coefficients: -1 then zeros.
    set_coefs_const(16'd0);
    coef_m[0] = 16'hFFFF;
    push_expect();
    send_coefs(-1);
    send_pixels(0, NPIX - 1, 1'b0);
    wait_drain();

    // Back-pressure on the first result.
    rdy_mode = 0;
    set_coefs_const(16'd1);
    push_expect();
    send_coefs(-1);
    send_pixels(0, 10, 1'b0);
    n = 0;
    @(negedge axi_clk);
    while (!m_axis_valid && n < 50) begin
      @(negedge axi_clk);
      n++;
    end
    if (n >= 50) chk("bp_valid_timeout", 320'(n), 320'(0));
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid",   320'(m_axis_valid), 320'(1'b1));
      chk("bp_data",    320'(m_axis_data),  320'(ACC'(54)));
      chk("bp_s_ready", 320'(s_axis_ready), 320'(1'b0));
      @(negedge axi_clk);
    end
    rdy_mode = 1;
    @(posedge axi_clk);
    #1;
    send_pixels(11, NPIX - 1, 1'b0);
    wait_drain();

    // Back-to-back frames, second with coefficients of 2.
    set_coefs_const(16'd1);
    push_expect();
    send_coefs(-1);
    send_pixels(0, NPIX - 1, 1'b0);
    set_coefs_const(16'd2);
    push_expect();
    send_coefs(-1);
    send_pixels(0, NPIX - 1, 1'b0);
    wait_drain();

    // Randomised frames with random back-pressure.
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin
      set_random();
      push_expect();
      send_coefs(-1);
      send_pixels(0, NPIX - 1, 1'b0);
    end
    wait_drain();
    rdy_mode = 1;

    // Last errors: extra last on coefficient beat 4, missing on pixel 16.
    set_coefs_const(16'd1);
    set_img_seq();
    push_expect();
    send_coefs(4);
    send_pixels(0, NPIX - 1, 1'b1);
    wait_drain();
    chk("err_sticky", 320'(err_last), 320'(1'b1));

    // Reset while the array holds a pending sum.
    set_random();
    push_expect();
    send_coefs(-1);
    send_pixels(0, 10, 1'b0);
    @(posedge axi_clk);
    #1;
    exp_err = 1'b0;
    do_reset();
    exp_q.delete();
    exp_ab_q.delete();
    repeat (4) @(posedge axi_clk);
    #1;
    chk("post_rst_no_output", 320'(m_axis_valid), 320'(1'b0));

    // Fresh coefficient load after reset.
    set_random();
    push_expect();
    send_coefs(-1);
    send_pixels(0, NPIX - 1, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_conv_window_controller.md
# axi_conv_window_controller

Parametrised successor to the single-window convolution controller. It accepts a K×K coefficient set, then a row-major image over one AXI-Stream slave. Internal line buffers form every valid K×K window, and the block drives each window plus the coefficients onto the external multiplier/adder array. Each returned sum is emitted on an AXI-Stream master with full back-pressure. It sits between the DMA MM2S stream and the DMA S2MM stream, in front of the existing multiplier array.

## Interface
- DATA_WIDTH, 16, pixel and coefficient width (unsigned pixels, signed coefficients)
- KERNEL_SIZE, 3, K; odd, 3..7
- IMG_WIDTH, 32, pixels per row; must be ≥ K
- IMG_HEIGHT, 32, rows per frame; must be ≥ K
- ACC_WIDTH, 2*DATA_WIDTH+6, width of the sum returned by the array and of the output data
- axi_clk  in  1  the single clock
- axi_reset_n  in  1  asynchronous active-low reset
- s_axis_valid / s_axis_ready  in / out  1  slave handshake
- s_axis_data  in  DATA_WIDTH  coefficient or pixel beat
- s_axis_last  in  1  end-of-coefficients / end-of-frame marker
- mul_a  out  K*K*DATA_WIDTH  flat window; element i = row*K+col, with element 0 the oldest pixel, at the LSBs
- mul_b  out  K*K*DATA_WIDTH  flat coefficients, same ordering
- mul_start  out  1  one-cycle request to the array
- mac_done  in  1  one-cycle pulse: sum valid
- mac_sum  in  ACC_WIDTH  window sum
- m_axis_valid / m_axis_ready  out / in  1  master handshake
- m_axis_data  out  ACC_WIDTH  result
- m_axis_last  out  1  final result of the frame
- busy  out  1  high in every state except LOAD_COEF with zero coefficients held
- err_last  out  1  sticky; s_axis_last misplaced or missing

## Operation
- FSM states: LOAD_COEF, FILL, ISSUE, WAIT_MAC, OUTPUT.
- **LOAD_COEF**
  - s_axis_ready=1.
  - Beats 0..K*K-1 are written to coef[i].
  - After beat K*K-1 the block goes to FILL and clears the row/column counters.
- **FILL**
  - s_axis_ready=1.
  - Each accepted pixel is pushed into K-1 line buffers (depth IMG_WIDTH each) and the K×K window shift register.
  - The column counter advances and wraps at IMG_WIDTH-1; the row counter increments on each wrap.
  - If row ≥ K-1 and col ≥ K-1 for the accepted pixel, go to ISSUE. Otherwise stay in FILL.
- **ISSUE**
  - s_axis_ready=0; mul_start=1 for exactly one cycle.
  - mul_a and mul_b are stable from ISSUE until mac_done.
  - Next state is WAIT_MAC.
- **WAIT_MAC**
  - On mac_done, latch mac_sum into the output register and go to OUTPUT.
  - There is no timeout.
- **OUTPUT**
  - m_axis_valid=1 while data and last are held stable.
  - On m_axis_ready, the next state is LOAD_COEF if this was the frame's final window, otherwise FILL.
- Result count per frame: (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1). m_axis_last is high only on the final result.
- s_axis_last checking:
  - Required on coefficient beat K*K-1 and on pixel IMG_WIDTH*IMG_HEIGHT-1.
  - Asserted on any other beat, or absent on those two beats, sets err_last.
  - Framing always follows the counters, never s_axis_last.
  - err_last is cleared only by reset.
- The window shift register is not cleared between rows. Windows are only issued when fully valid, so stale columns are never used.
- The block holds no arithmetic of its own; mac_sum passes through unmodified.

## Timing
- Reset values:
  - FSM in LOAD_COEF; counters 0; coef, window and line buffers 0.
  - s_axis_ready=0 during reset, then 1 on the first clock edge after deassertion.
  - mul_start=0, mul_a=0, mul_b=0, m_axis_valid=0, m_axis_data=0, m_axis_last=0, busy=0, err_last=0.
- Pixel completing a window accepted at cycle N: mul_start at N+1; s_axis_ready low from N+1.
- mac_done at cycle M: m_axis_valid at M+1.
- Best case (m_axis_ready high): s_axis_ready returns at M+2, i.e. a 3-cycle overhead plus array latency per window.
- Pixels that do not complete a window are accepted at one per cycle.
- mac_done outside WAIT_MAC is ignored.
- Reset mid-frame aborts everything: the coefficients must be reloaded, and the array's pending sum is discarded.

## Structure
- Shared package `conv_pkg`: FSM state encoding, K*K and result-count localparams, flat-bus index function.
- Sub-module `conv_line_buffer` (single-port RAM-style shift line, parameters DATA_WIDTH and IMG_WIDTH), instantiated K-1 times.

## Test plan
Use K=3, IMG_WIDTH=4, IMG_HEIGHT=4, DATA_WIDTH=16. The bench array model pulses mac_done 4 cycles after mul_start, returning the dot product.
- **Reset state:** assert reset mid-frame → all outputs at their reset values; a fresh coefficient load then yields correct results.
- **Basic frame:** 9 coefficients of 1, then pixels 1..16 with m_axis_ready=1 → results 54, 63, 90, 99; m_axis_last only on 99; err_last=0.
- **Signed coefficients:** coefficients −1 then eight 0s, pixels 1..16 → results −1, −2, −5, −6 (two's complement in ACC_WIDTH).
- **Back-pressure:** m_axis_ready held low for 10 cycles at the first result → m_axis_data holds 54, s_axis_ready=0 throughout, and the following results are unchanged.
- **Last errors:** s_axis_last on coefficient beat 4, and absent on pixel 16 → err_last rises at beat 4 and stays high; the four results are still correct.
- **Back-to-back frames:** two frames without idle cycles, the second with coefficients of 2 → the second frame's results are 108, 126, 180, 198.
